// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-capturing interrupt controller with a software mask,
// highest-index-wins selection, and a req/ack/eoi handshake to the CPU.
// Only one interrupt is in service at a time.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | nothing presented; latch the best unmasked pending source
// S_REQ     | irq_req high, irq_id frozen until ack or withdraw-by-mask
// S_SERVICE | CPU is servicing irq_id; wait for eoi
module irq_ctrl #(
  parameter int ID_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2**ID_W-1:0]   irq_src_i,
  input  logic                 mask_we_i,
  input  logic [2**ID_W-1:0]   mask_din_i,
  input  logic                 irq_ack_i,
  input  logic                 eoi_i,
  output logic                 irq_req_o,
  output logic [ID_W-1:0]      irq_id_o,
  output logic                 in_service_o,
  output logic [2**ID_W-1:0]   pending_o,
  output logic [2**ID_W-1:0]   mask_o
);

  localparam int N = 2**ID_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    src_q;
  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    mask_q, mask_d;
  logic [ID_W-1:0] irq_id_q;
  logic            irq_req_q;
  logic            in_service_q;

  logic [N-1:0]    rise;
  logic [N-1:0]    clr;
  logic [N-1:0]    act;
  logic [ID_W-1:0] sel_id;
  logic            sel_v;
  logic            ack_ok;

  // Edge detect, pending update (a new rise beats a same-cycle clear), mask load
  always_comb begin
    rise      = irq_src_i & ~src_q;
    ack_ok    = (state_q == S_REQ) && irq_ack_i;
    clr       = '0;
    if (ack_ok) clr[irq_id_q] = 1'b1;
    pending_d = (pending_q & ~clr) | rise;
    mask_d    = mask_we_i ? mask_din_i : mask_q;
  end

  // Priority select: the highest set bit of the enabled pending vector wins
  always_comb begin
    act    = pending_q & mask_q;
    sel_v  = |act;
    sel_id = '0;
    for (int i = 0; i < N; i++) begin
      if (act[i]) sel_id = ID_W'(i);
    end
  end

  // Source history, pending and mask registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      src_q     <= irq_src_i;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Handshake FSM with registered Moore outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      irq_id_q     <= '0;
      irq_req_q    <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel_v) begin
            state_q   <= S_REQ;
            irq_id_q  <= sel_id;
            irq_req_q <= 1'b1;
          end
        end
        S_REQ: begin
          // ack takes precedence over a mask-driven withdraw
          if (irq_ack_i) begin
            state_q      <= S_SERVICE;
            irq_req_q    <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!act[irq_id_q]) begin
            state_q   <= S_IDLE;
            irq_req_q <= 1'b0;
          end
        end
        S_SERVICE: begin
          if (eoi_i) begin
            state_q      <= S_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          irq_req_q    <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req_o    = irq_req_q;
  assign irq_id_o     = irq_id_q;
  assign in_service_o = in_service_q;
  assign pending_o    = pending_q;
  assign mask_o       = mask_q;

endmodule
